// File: rtl/mem_port_arbiter_pkg.sv
// Shared widths, owner encoding and constants for the CPU memory-port arbiter.
package arm_mem_pkg;

    localparam int unsigned MEM_ADDR_W = 12;
    localparam int unsigned MEM_DATA_W = 32;
    localparam int unsigned MEM_BE_W   = 4;
    localparam int unsigned STARVE_W   = 4;
    localparam int unsigned STAT_W     = 16;

    localparam logic [MEM_BE_W-1:0] BE_ALL = 4'hF;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_LS   = 2'd2
    } mem_owner_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch, load/store and RAM signals of the shared memory port.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = arm_mem_pkg::MEM_ADDR_W,
    parameter int unsigned DATA_W = arm_mem_pkg::MEM_DATA_W
) ();

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    logic              ls_req;
    logic              ls_we;
    logic [3:0]        ls_be;
    logic [ADDR_W-1:0] ls_addr;
    logic [DATA_W-1:0] ls_wdata;
    logic              ls_gnt;
    logic              ls_rvalid;
    logic [DATA_W-1:0] ls_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [3:0]        mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // Requestors and RAM side
    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata,
        output ls_req, ls_we, ls_be, ls_addr, ls_wdata,
        input  ls_gnt, ls_rvalid, ls_rdata,
        input  mem_en, mem_we, mem_be, mem_addr, mem_wdata,
        output mem_rdata
    );

    // Arbiter side
    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata,
        input  ls_req, ls_we, ls_be, ls_addr, ls_wdata,
        output ls_gnt, ls_rvalid, ls_rdata,
        output mem_en, mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_rdata
    );

endinterface

// File: rtl/mem_port_arbiter_prio_sel.sv
// Combinational grant picker: load/store priority unless fetch has starved.
module mem_arb_prio_sel (
    input  logic if_req,
    input  logic ls_req,
    input  logic starve_hit,
    output logic if_gnt,
    output logic ls_gnt
);

    always_comb begin
        if_gnt = 1'b0;
        ls_gnt = 1'b0;
        if (if_req && ls_req && starve_hit) begin
            if_gnt = 1'b1;
        end else if (ls_req) begin
            ls_gnt = 1'b1;
        end else if (if_req) begin
            if_gnt = 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter between instruction fetch and load/store.
// Optional grant/stall statistics are enabled by MEM_PORT_ARBITER_STATS_EN.
module mem_port_arbiter
    import arm_mem_pkg::*;
#(
    parameter int unsigned ADDR_W     = MEM_ADDR_W,
    parameter int unsigned DATA_W     = MEM_DATA_W,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    mem_port_arbiter_if.slave  bus,
    output logic               busy
`ifdef MEM_PORT_ARBITER_STATS_EN
    ,
    output logic [STAT_W-1:0]  stat_if_grants,
    output logic [STAT_W-1:0]  stat_ls_grants,
    output logic [STAT_W-1:0]  stat_if_stalls
`endif
);

    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

    logic [STARVE_W-1:0] starve_cnt;
    logic                starve_hit;
    logic                if_gnt;
    logic                ls_gnt;
    mem_owner_t          rsp_own;
    mem_owner_t          rsp_own_nxt;
    logic [ADDR_W-1:0]   win_addr;
    logic [DATA_W-1:0]   win_wdata;

    assign starve_hit = (starve_cnt == STARVE_LIM);

    // Requests are masked during reset so nothing is granted there.
    mem_arb_prio_sel u_prio_sel (
        .if_req     (bus.if_req && reset_n),
        .ls_req     (bus.ls_req && reset_n),
        .starve_hit (starve_hit),
        .if_gnt     (if_gnt),
        .ls_gnt     (ls_gnt)
    );

    assign bus.if_gnt = if_gnt;
    assign bus.ls_gnt = ls_gnt;

    // RAM drive from the winner; everything zero when idle.
    always_comb begin
        win_addr      = '0;
        win_wdata     = '0;
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_be    = '0;
        if (if_gnt) begin
            win_addr   = bus.if_addr;
            bus.mem_en = 1'b1;
            bus.mem_be = BE_ALL;
        end else if (ls_gnt) begin
            win_addr   = bus.ls_addr;
            win_wdata  = bus.ls_wdata;
            bus.mem_en = 1'b1;
            bus.mem_we = bus.ls_we;
            bus.mem_be = bus.ls_we ? bus.ls_be : BE_ALL;
        end
        bus.mem_addr  = win_addr;
        bus.mem_wdata = win_wdata;
    end

    // Consecutive cycles fetch has asked and lost, saturating at the limit.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            starve_cnt <= '0;
        end else if (bus.if_req && !if_gnt) begin
            if (!starve_hit) begin
                starve_cnt <= starve_cnt + STARVE_W'(1);
            end
        end else begin
            starve_cnt <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rsp_own <= OWN_NONE;
        end else begin
            rsp_own <= rsp_own_nxt;
        end
    end

    always_comb begin
        rsp_own_nxt = OWN_NONE;
        if (if_gnt) begin
            rsp_own_nxt = OWN_IF;
        end else if (ls_gnt && !bus.ls_we) begin
            rsp_own_nxt = OWN_LS;
        end
    end

    // A read granted just before reset must not surface while reset is held.
    assign bus.if_rvalid = reset_n && (rsp_own == OWN_IF);
    assign bus.ls_rvalid = reset_n && (rsp_own == OWN_LS);
    assign bus.if_rdata  = bus.if_rvalid ? bus.mem_rdata : '0;
    assign bus.ls_rdata  = bus.ls_rvalid ? bus.mem_rdata : '0;
    assign busy          = reset_n && (rsp_own != OWN_NONE);

`ifdef MEM_PORT_ARBITER_STATS_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stat_if_grants <= '0;
            stat_ls_grants <= '0;
            stat_if_stalls <= '0;
        end else begin
            if (if_gnt && (stat_if_grants != '1)) begin
                stat_if_grants <= stat_if_grants + STAT_W'(1);
            end
            if (ls_gnt && (stat_ls_grants != '1)) begin
                stat_ls_grants <= stat_ls_grants + STAT_W'(1);
            end
            if (bus.if_req && !if_gnt && (stat_if_stalls != '1)) begin
                stat_if_stalls <= stat_if_stalls + STAT_W'(1);
            end
        end
    end
`endif

    // Address must stay put while a request waits for its grant.
    a_if_addr_hold: assert property (@(posedge clk) disable iff (!reset_n)
        (bus.if_req && !if_gnt) |=> (!bus.if_req || $stable(bus.if_addr)));
    a_ls_addr_hold: assert property (@(posedge clk) disable iff (!reset_n)
        (bus.ls_req && !ls_gnt) |=> (!bus.ls_req || $stable(bus.ls_addr)));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized checks of mem_port_arbiter against a cycle-level reference model.
module tb_mem_port_arbiter;
    import arm_mem_pkg::*;

    localparam int SM = 4;

    logic clk;
    logic reset_n;
    logic busy;

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(.STARVE_MAX(SM)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: consecutive fetch losses and owner of the pending read.
    int loss = 0;
    int own  = 0;
    logic e_if, e_ls;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_cycle(input string tag);
        logic [3:0]  e_be;
        logic [11:0] e_addr;
        logic [31:0] e_wdata;
        logic        e_ifv, e_lsv;
        @(negedge clk);
        e_if = 1'b0;
        e_ls = 1'b0;
        if (reset_n) begin
            if (bus.if_req && bus.ls_req && loss >= SM) e_if = 1'b1;
            else if (bus.ls_req)                         e_ls = 1'b1;
            else if (bus.if_req)                         e_if = 1'b1;
        end
        e_be    = e_if ? 4'hF : (e_ls ? (bus.ls_we ? bus.ls_be : 4'hF) : 4'h0);
        e_addr  = e_if ? bus.if_addr : (e_ls ? bus.ls_addr : 12'h0);
        e_wdata = e_ls ? bus.ls_wdata : 32'h0;
        e_ifv   = reset_n && (own == 1);
        e_lsv   = reset_n && (own == 2);
        chk({tag, ":if_gnt"},    64'(bus.if_gnt),    64'(e_if));
        chk({tag, ":ls_gnt"},    64'(bus.ls_gnt),    64'(e_ls));
        chk({tag, ":mem_en"},    64'(bus.mem_en),    64'(e_if | e_ls));
        chk({tag, ":mem_we"},    64'(bus.mem_we),    64'(e_ls & bus.ls_we));
        chk({tag, ":mem_be"},    64'(bus.mem_be),    64'(e_be));
        chk({tag, ":mem_addr"},  64'(bus.mem_addr),  64'(e_addr));
        chk({tag, ":mem_wdata"}, 64'(bus.mem_wdata), 64'(e_wdata));
        chk({tag, ":if_rvalid"}, 64'(bus.if_rvalid), 64'(e_ifv));
        chk({tag, ":ls_rvalid"}, 64'(bus.ls_rvalid), 64'(e_lsv));
        chk({tag, ":if_rdata"},  64'(bus.if_rdata),  e_ifv ? 64'(bus.mem_rdata) : 64'h0);
        chk({tag, ":ls_rdata"},  64'(bus.ls_rdata),  e_lsv ? 64'(bus.mem_rdata) : 64'h0);
        chk({tag, ":busy"},      64'(busy),          64'(e_ifv | e_lsv));
    endtask

    task automatic advance();
        @(posedge clk);
        if (!reset_n) begin
            loss = 0;
            own  = 0;
        end else begin
            if (bus.if_req && !e_if) loss++;
            else                     loss = 0;
            own = e_if ? 1 : ((e_ls && !bus.ls_we) ? 2 : 0);
        end
        #1;
        bus.mem_rdata = $urandom;
    endtask

    task automatic idle_inputs();
        bus.if_req   = 1'b0;
        bus.if_addr  = '0;
        bus.ls_req   = 1'b0;
        bus.ls_we    = 1'b0;
        bus.ls_be    = '0;
        bus.ls_addr  = '0;
        bus.ls_wdata = '0;
    endtask

    initial begin
        #100000;
        $fatal(1, "FAIL watchdog: observed timeout expected finish");
    end

    initial begin
        reset_n = 1'b0;
        idle_inputs();
        bus.mem_rdata = '0;

        // Reset, including a request presented during reset
        check_cycle("rst0");
        advance();
        bus.if_req = 1'b1; bus.if_addr = 12'h3C0;
        check_cycle("rst_req");
        chk("rst_req:no_gnt", 64'(bus.if_gnt), 64'h0);
        advance();
        reset_n = 1'b1;
        idle_inputs();
        check_cycle("idle");
        advance();

        // Fetch-only read
        bus.if_req = 1'b1; bus.if_addr = 12'h010;
        check_cycle("fetch");
        chk("fetch:gnt", 64'(bus.if_gnt), 64'h1);
        chk("fetch:addr", 64'(bus.mem_addr), 64'h010);
        advance();
        bus.if_req = 1'b0;
        bus.mem_rdata = 32'hE2811004;
        check_cycle("fetch_rsp");
        chk("fetch_rsp:rvalid", 64'(bus.if_rvalid), 64'h1);
        chk("fetch_rsp:rdata", 64'(bus.if_rdata), 64'hE2811004);
        chk("fetch_rsp:ls_quiet", 64'(bus.ls_rvalid), 64'h0);
        advance();

        // Conflict: load wins, fetch follows
        bus.if_req = 1'b1; bus.if_addr = 12'h050;
        bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_addr = 12'h100; bus.ls_wdata = 32'h1234;
        check_cycle("conf");
        chk("conf:ls_gnt", 64'(bus.ls_gnt), 64'h1);
        chk("conf:if_gnt", 64'(bus.if_gnt), 64'h0);
        chk("conf:addr", 64'(bus.mem_addr), 64'h100);
        advance();
        bus.ls_req = 1'b0;
        check_cycle("conf2");
        chk("conf2:if_gnt", 64'(bus.if_gnt), 64'h1);
        advance();
        bus.if_req = 1'b0;
        check_cycle("conf3");
        advance();

        // Starvation: four load wins, forced fetch, then load again
        bus.if_req = 1'b1; bus.if_addr = 12'h060;
        bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_addr = 12'h104;
        for (int i = 0; i < SM; i++) begin
            check_cycle("starve");
            chk("starve:ls_gnt", 64'(bus.ls_gnt), 64'h1);
            advance();
        end
        check_cycle("forced");
        chk("forced:if_gnt", 64'(bus.if_gnt), 64'h1);
        chk("forced:ls_gnt", 64'(bus.ls_gnt), 64'h0);
        advance();
        chk("forced:starve_cnt", 64'(dut.starve_cnt), 64'h0);
        bus.if_addr = 12'h061;
        check_cycle("resume");
        chk("resume:ls_gnt", 64'(bus.ls_gnt), 64'h1);
        advance();
        idle_inputs();
        check_cycle("drain");
        advance();

        // Byte-masked store
        bus.ls_req = 1'b1; bus.ls_we = 1'b1; bus.ls_be = 4'b0011;
        bus.ls_addr = 12'h020; bus.ls_wdata = 32'h0000BEEF;
        check_cycle("store");
        chk("store:mem_en", 64'(bus.mem_en), 64'h1);
        chk("store:mem_we", 64'(bus.mem_we), 64'h1);
        chk("store:mem_be", 64'(bus.mem_be), 64'h3);
        advance();
        idle_inputs();
        check_cycle("store_rsp");
        chk("store_rsp:ls_rvalid", 64'(bus.ls_rvalid), 64'h0);
        advance();

        // Pipelined reads IF, LS, IF
        bus.if_req = 1'b1; bus.if_addr = 12'h000;
        check_cycle("pipe0");
        advance();
        bus.if_req = 1'b0;
        bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_addr = 12'h200;
        bus.mem_rdata = 32'hA1A1A1A1;
        check_cycle("pipe1");
        chk("pipe1:if_rdata", 64'(bus.if_rdata), 64'hA1A1A1A1);
        advance();
        bus.ls_req = 1'b0;
        bus.if_req = 1'b1; bus.if_addr = 12'h001;
        bus.mem_rdata = 32'hB2B2B2B2;
        check_cycle("pipe2");
        chk("pipe2:ls_rdata", 64'(bus.ls_rdata), 64'hB2B2B2B2);
        advance();
        bus.if_req = 1'b0;
        bus.mem_rdata = 32'hC3C3C3C3;
        check_cycle("pipe3");
        chk("pipe3:if_rdata", 64'(bus.if_rdata), 64'hC3C3C3C3);
        advance();

        // Reset in the cycle after a fetch grant
        bus.if_req = 1'b1; bus.if_addr = 12'h0A0;
        check_cycle("mrst0");
        chk("mrst0:if_gnt", 64'(bus.if_gnt), 64'h1);
        advance();
        reset_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check_cycle("mrst");
            chk("mrst:if_rvalid", 64'(bus.if_rvalid), 64'h0);
            chk("mrst:busy", 64'(busy), 64'h0);
            advance();
        end
        reset_n = 1'b1;
        check_cycle("mrst_exit");
        chk("mrst_exit:if_gnt", 64'(bus.if_gnt), 64'h1);
        advance();
        idle_inputs();
        check_cycle("mrst_idle");
        advance();

        // Randomized traffic honouring the hold-until-grant protocol
        for (int c = 0; c < 400; c++) begin
            logic g_if, g_ls;
            g_if = e_if;
            g_ls = e_ls;
            if (!bus.if_req || g_if) begin
                bus.if_req  = ($urandom_range(0, 99) < 60);
                bus.if_addr = 12'($urandom);
            end else if ($urandom_range(0, 9) == 0) begin
                bus.if_req = 1'b0;
            end
            if (!bus.ls_req || g_ls) begin
                bus.ls_req   = ($urandom_range(0, 99) < 55);
                bus.ls_we    = 1'($urandom);
                bus.ls_be    = 4'($urandom);
                bus.ls_addr  = 12'($urandom);
                bus.ls_wdata = $urandom;
            end else if ($urandom_range(0, 9) == 0) begin
                bus.ls_req = 1'b0;
            end
            reset_n = ($urandom_range(0, 99) != 0);
            check_cycle("rand");
            advance();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the CPU's single-port synchronous RAM between the instruction-fetch path and the load/store path (STR/LDR execution).
- Grants at most one access per cycle.
- Tags each read with its owner and returns the read data one cycle later on that owner's response channel.
- Load/store wins by default. A starvation counter forces a fetch grant after STARVE_MAX consecutive fetch losses.

Parameters:
ADDR_W, 12, word address width (4096-word RAM)
DATA_W, 32, data word width
STARVE_MAX, 4, consecutive lost fetch-request cycles before fetch is forced; legal range 1..15

Ports:
clk  input  1  clock
reset_n  input  1  synchronous, active-low reset
if_req  input  1  fetch request; held with if_addr stable until if_gnt
if_addr  input  ADDR_W  fetch word address
if_gnt  output  1  fetch request accepted this cycle
if_rvalid  output  1  fetch read data valid
if_rdata  output  DATA_W  fetch read data
ls_req  input  1  load/store request; held stable until ls_gnt
ls_we  input  1  1 = store, 0 = load
ls_be  input  4  byte enables for stores
ls_addr  input  ADDR_W  load/store word address
ls_wdata  input  DATA_W  store data
ls_gnt  output  1  load/store request accepted this cycle
ls_rvalid  output  1  load read data valid
ls_rdata  output  DATA_W  load read data
mem_en  output  1  RAM access enable
mem_we  output  1  RAM write enable
mem_be  output  4  RAM byte enables
mem_addr  output  ADDR_W  RAM address
mem_wdata  output  DATA_W  RAM write data
mem_rdata  input  DATA_W  RAM read data, valid the cycle after a read enable
busy  output  1  a read response is pending

Behaviour:
- Grant is combinational from the requests and the starve counter. if_gnt and ls_gnt are never both 1.
- Grant rule:
  - If if_req, ls_req and starve_cnt==STARVE_MAX: fetch wins.
  - Otherwise, if ls_req: load/store wins.
  - Otherwise, if if_req: fetch wins.
- RAM drive on a grant:
  - mem_en=1; mem_addr, mem_we and mem_wdata come from the winner.
  - mem_we=0 on fetch grants.
  - mem_be = ls_be on stores, 4'hF otherwise.
  - With no grant, all mem_* outputs are 0.
- Starve counter (4-bit register starve_cnt):
  - Increments, saturating at STARVE_MAX, when if_req=1 and if_gnt=0.
  - Clears on if_gnt or when if_req=0.
- Response FSM, owner register rsp_own with states OWN_NONE / OWN_IF / OWN_LS:
  - A read grant in cycle N sets rsp_own for cycle N+1.
  - Writes and idle cycles leave rsp_own = OWN_NONE.
  - Back-to-back reads are fully pipelined, so the next state is computed every cycle.
- Outputs in cycle N+1:
  - if_rvalid = (rsp_own==OWN_IF); ls_rvalid = (rsp_own==OWN_LS).
  - if_rdata and ls_rdata = mem_rdata, gated to 0 when the matching rvalid is 0.
  - busy = (rsp_own != OWN_NONE).
- Latency:
  - Read: grant to rvalid is exactly 1 cycle.
  - Store: complete at ls_gnt; no rvalid is produced.
- Reset:
  - While reset_n==0: all gnt, rvalid and mem_* outputs are 0.
  - rsp_own=OWN_NONE and starve_cnt=0.
  - A request presented during reset is not granted.
  - A read granted in the cycle before reset asserts produces no rvalid.
- Requests dropped before grant are legal and leave no state, apart from the starve counter clearing.
- An address change while a request is held before grant is a protocol violation; the simulation assertion fires.

Optional Feature:
Macro: MEM_PORT_ARBITER_STATS_EN
- Defined:
  - Adds 16-bit saturating outputs stat_if_grants, stat_ls_grants and stat_if_stalls (cycles with if_req && !if_gnt).
  - All three clear on reset.
- Undefined: those ports and registers do not exist, and the rest of the behaviour is identical.

Decomposition:
- Package arm_mem_pkg holds:
  - localparams MEM_ADDR_W=12 and MEM_DATA_W=32;
  - the owner enum mem_owner_t with OWN_NONE=2'd0, OWN_IF=2'd1, OWN_LS=2'd2;
  - the constant BE_ALL=4'hF.
- One sub-module is natural: mem_arb_prio_sel, a combinational grant picker. Inputs are if_req, ls_req and starve_hit. Outputs are if_gnt and ls_gnt.

Test Plan:
- Fetch-only read: if_req, if_addr=12'h010, mem_rdata=32'hE2811004 the next cycle → if_gnt in cycle 0; if_rvalid=1 with if_rdata=32'hE2811004 in cycle 1; ls_* quiet.
- Conflict: if_req and ls_req (load, addr 12'h100) both high → ls_gnt=1, if_gnt=0, mem_addr=12'h100; if_gnt follows in the next cycle after ls_req drops.
- Starvation with STARVE_MAX=4: ls_req held continuously with if_req → ls_gnt for 4 cycles, if_gnt on cycle 5, then ls_gnt resumes; starve_cnt is 0 after the forced grant.
- Store: ls_we=1, ls_be=4'b0011, ls_addr=12'h020, ls_wdata=32'h0000BEEF → mem_en=1, mem_we=1, mem_be=4'b0011 in the grant cycle; no ls_rvalid in the following cycle.
- Pipelined reads: fetch at 12'h000, then load at 12'h200, then fetch at 12'h001 on consecutive cycles → the rvalids alternate IF, LS, IF, each carrying that cycle's mem_rdata.
- Reset mid-operation: fetch read granted, reset_n=0 in the next cycle → if_rvalid=0, busy=0, all gnt=0 while reset is held; normal grants resume in the first cycle after reset_n=1.
